// File: rtl/time_bcd_formatter.sv
// Binary hh:mm:ss to two-digit BCD formatter with 12/24-hour mapping.
// Captures a sample on i_start, runs a shift-add-3 engine on all fields in parallel, then registers the digits.
module time_bcd_formatter #(
  parameter int HOUR_W        = 5,
  parameter int MINSEC_W      = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_12h_mode,
  input  logic [HOUR_W-1:0]   i_hours,
  input  logic [MINSEC_W-1:0] i_minutes,
  input  logic [MINSEC_W-1:0] i_seconds,
  output logic                o_busy,
  output logic                o_valid,
  output logic [3:0]          o_hour_tens,
  output logic [3:0]          o_hour_ones,
  output logic [3:0]          o_min_tens,
  output logic [3:0]          o_min_ones,
  output logic [3:0]          o_sec_tens,
  output logic [3:0]          o_sec_ones,
  output logic                o_am_pm,
  output logic                o_range_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam int CNT_W = 3;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                pm_q, pm_d;
  logic                err_q, err_d;
  logic [MINSEC_W-1:0] hr_sh_q, hr_sh_d;
  logic [MINSEC_W-1:0] mn_sh_q, mn_sh_d;
  logic [MINSEC_W-1:0] sc_sh_q, sc_sh_d;
  logic [7:0]          hr_bcd_q, hr_bcd_d;
  logic [7:0]          mn_bcd_q, mn_bcd_d;
  logic [7:0]          sc_bcd_q, sc_bcd_d;
  logic [3:0]          hour_tens_q, hour_tens_d;
  logic [3:0]          hour_ones_q, hour_ones_d;
  logic [3:0]          min_tens_q, min_tens_d;
  logic [3:0]          min_ones_q, min_ones_d;
  logic [3:0]          sec_tens_q, sec_tens_d;
  logic [3:0]          sec_ones_q, sec_ones_d;
  logic                am_pm_q, am_pm_d;
  logic                valid_q, valid_d;
  logic                range_err_q, range_err_d;

  // 12h mode: 0 and 12 show as 12, everything else (including >=24) wraps mod 12.
  function automatic logic [MINSEC_W-1:0] map_hours(input logic [HOUR_W-1:0] h,
                                                    input logic mode12);
    int v;
    v = int'(h);
    if (mode12) begin
      if (v == 0) begin
        v = 12;
      end else if (v != 12) begin
        for (int i = 0; i < 6; i++) begin
          if (v >= 12) v = v - 12;
        end
      end
    end
    return MINSEC_W'(v);
  endfunction

  function automatic logic [7:0] dd_step(input logic [7:0] bcd, input logic bit_in);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = bcd[3:0];
    hi = bcd[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi[2:0], lo, bit_in};
  endfunction

  function automatic logic [3:0] blank_tens(input logic [3:0] tens, input logic mode12);
    return ((BLANK_LEADING != 0) && mode12 && (tens == 4'd0)) ? 4'hF : tens;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    pm_d        = pm_q;
    err_d       = err_q;
    hr_sh_d     = hr_sh_q;
    mn_sh_d     = mn_sh_q;
    sc_sh_d     = sc_sh_q;
    hr_bcd_d    = hr_bcd_q;
    mn_bcd_d    = mn_bcd_q;
    sc_bcd_d    = sc_bcd_q;
    hour_tens_d = hour_tens_q;
    hour_ones_d = hour_ones_q;
    min_tens_d  = min_tens_q;
    min_ones_d  = min_ones_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    am_pm_d     = am_pm_q;
    range_err_d = range_err_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_SHIFT;
          mode_d   = i_12h_mode;
          pm_d     = i_12h_mode && (int'(i_hours) >= 12);
          err_d    = (int'(i_hours) >= 24) || (int'(i_minutes) >= 60) ||
                     (int'(i_seconds) >= 60);
          hr_sh_d  = map_hours(i_hours, i_12h_mode);
          mn_sh_d  = i_minutes;
          sc_sh_d  = i_seconds;
          hr_bcd_d = 8'd0;
          mn_bcd_d = 8'd0;
          sc_bcd_d = 8'd0;
          cnt_d    = CNT_W'(MINSEC_W);
        end
      end
      S_SHIFT: begin
        hr_bcd_d = dd_step(hr_bcd_q, hr_sh_q[MINSEC_W-1]);
        mn_bcd_d = dd_step(mn_bcd_q, mn_sh_q[MINSEC_W-1]);
        sc_bcd_d = dd_step(sc_bcd_q, sc_sh_q[MINSEC_W-1]);
        hr_sh_d  = hr_sh_q << 1;
        mn_sh_d  = mn_sh_q << 1;
        sc_sh_d  = sc_sh_q << 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        hour_tens_d = blank_tens(hr_bcd_q[7:4], mode_q);
        hour_ones_d = hr_bcd_q[3:0];
        min_tens_d  = mn_bcd_q[7:4];
        min_ones_d  = mn_bcd_q[3:0];
        sec_tens_d  = sc_bcd_q[7:4];
        sec_ones_d  = sc_bcd_q[3:0];
        am_pm_d     = pm_q;
        range_err_d = err_q;
        valid_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible outputs: reset to a known display state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      hour_tens_q <= 4'd0;
      hour_ones_q <= 4'd0;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      am_pm_q     <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      hour_tens_q <= hour_tens_d;
      hour_ones_q <= hour_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      am_pm_q     <= am_pm_d;
      range_err_q <= range_err_d;
    end
  end

  // Working registers are always reloaded on start, so they carry no reset.
  always_ff @(posedge i_clk) begin
    mode_q   <= mode_d;
    pm_q     <= pm_d;
    err_q    <= err_d;
    hr_sh_q  <= hr_sh_d;
    mn_sh_q  <= mn_sh_d;
    sc_sh_q  <= sc_sh_d;
    hr_bcd_q <= hr_bcd_d;
    mn_bcd_q <= mn_bcd_d;
    sc_bcd_q <= sc_bcd_d;
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_valid     = valid_q;
  assign o_hour_tens = hour_tens_q;
  assign o_hour_ones = hour_ones_q;
  assign o_min_tens  = min_tens_q;
  assign o_min_ones  = min_ones_q;
  assign o_sec_tens  = sec_tens_q;
  assign o_sec_ones  = sec_ones_q;
  assign o_am_pm     = am_pm_q;
  assign o_range_err = range_err_q;

endmodule

// File: tb/tb_time_bcd_formatter.sv
// Directed-vector bench for time_bcd_formatter; a second instance covers BLANK_LEADING=0.
module tb_time_bcd_formatter;

  logic       clk = 1'b0;
  logic       i_reset, i_start, i_12h_mode;
  logic [4:0] i_hours;
  logic [5:0] i_minutes, i_seconds;
  logic       o_busy, o_valid, o_am_pm, o_range_err;
  logic [3:0] o_hour_tens, o_hour_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones;
  logic       nb_busy, nb_valid, nb_am_pm, nb_range_err;
  logic [3:0] nb_ht, nb_ho, nb_mt, nb_mo, nb_st, nb_so;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  time_bcd_formatter dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_12h_mode(i_12h_mode),
    .i_hours(i_hours), .i_minutes(i_minutes), .i_seconds(i_seconds),
    .o_busy(o_busy), .o_valid(o_valid),
    .o_hour_tens(o_hour_tens), .o_hour_ones(o_hour_ones),
    .o_min_tens(o_min_tens), .o_min_ones(o_min_ones),
    .o_sec_tens(o_sec_tens), .o_sec_ones(o_sec_ones),
    .o_am_pm(o_am_pm), .o_range_err(o_range_err)
  );

  time_bcd_formatter #(.BLANK_LEADING(0)) dut_nb (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_12h_mode(i_12h_mode),
    .i_hours(i_hours), .i_minutes(i_minutes), .i_seconds(i_seconds),
    .o_busy(nb_busy), .o_valid(nb_valid),
    .o_hour_tens(nb_ht), .o_hour_ones(nb_ho),
    .o_min_tens(nb_mt), .o_min_ones(nb_mo),
    .o_sec_tens(nb_st), .o_sec_ones(nb_so),
    .o_am_pm(nb_am_pm), .o_range_err(nb_range_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eh, input logic [7:0] em,
                         input logic [7:0] es, input logic epm, input logic eerr);
    chk({tag, "_hr"},  {o_hour_tens, o_hour_ones}, eh);
    chk({tag, "_min"}, {o_min_tens, o_min_ones}, em);
    chk({tag, "_sec"}, {o_sec_tens, o_sec_ones}, es);
    chk({tag, "_pm"},  o_am_pm, epm);
    chk({tag, "_err"}, o_range_err, eerr);
  endtask

  // Called #1 after a posedge; drives start into the next edge (edge N) and returns #1 after it.
  task automatic start_conv(input logic m, input logic [4:0] h, input logic [5:0] mi,
                            input logic [5:0] s);
    i_12h_mode = m; i_hours = h; i_minutes = mi; i_seconds = s; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Waits for o_valid (bounded), checking latency from edge N and busy throughout.
  task automatic wait_valid(input string tag, input int lat0);
    int lat;
    bit got;
    bit busy_ok;
    lat = lat0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (o_valid) got = 1'b1;
      else if (!o_busy) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, lat, 7);
    chk({tag, "_busyhold"}, busy_ok, 1);
    chk({tag, "_busyend"}, o_busy, 0);
  endtask

  task automatic conv(input string tag, input logic m, input logic [4:0] h,
                      input logic [5:0] mi, input logic [5:0] s);
    start_conv(m, h, mi, s);
    chk({tag, "_busy0"}, o_busy, 1);
    wait_valid(tag, 0);
  endtask

  initial begin
    int vcnt;
    int bcnt;
    i_reset = 1'b1; i_start = 1'b0; i_12h_mode = 1'b0;
    i_hours = '0; i_minutes = '0; i_seconds = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    conv("t24", 1'b0, 5'd13, 6'd45, 6'd9);
    chk_out("t24", 8'h13, 8'h45, 8'h09, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t24_vpulse", o_valid, 0);

    conv("midnight", 1'b1, 5'd0, 6'd0, 6'd0);
    chk_out("midnight", 8'h12, 8'h00, 8'h00, 1'b0, 1'b0);

    conv("pm13", 1'b1, 5'd13, 6'd5, 6'd59);
    chk_out("pm13", 8'hF1, 8'h05, 8'h59, 1'b1, 1'b0);

    conv("noon", 1'b1, 5'd12, 6'd0, 6'd0);
    chk_out("noon", 8'h12, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("noon_nb_hr", {nb_ht, nb_ho}, 8'h12);

    conv("nine", 1'b1, 5'd9, 6'd30, 6'd0);
    chk_out("nine", 8'hF9, 8'h30, 8'h00, 1'b0, 1'b0);
    chk("nine_nb_hr", {nb_ht, nb_ho}, 8'h09);
    chk("nine_nb_pm", nb_am_pm, 0);
    chk("nine_nb_valid", nb_valid, 1);

    // Mode/inputs change at N+2 and a second start at N+3 must not disturb the sample.
    start_conv(1'b0, 5'd7, 6'd8, 6'd9);
    @(posedge clk); #1;
    i_12h_mode = 1'b1; i_hours = 5'd15; i_minutes = 6'd33; i_seconds = 6'd44;
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_valid("busyign", 3);
    chk_out("busyign", 8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    start_conv(1'b0, 5'd21, 6'd22, 6'd23);
    chk("b2b_busy", o_busy, 1);
    chk("b2b_novalid", o_valid, 0);
    wait_valid("b2b", 0);
    chk_out("b2b", 8'h21, 8'h22, 8'h23, 1'b0, 1'b0);

    conv("range", 1'b0, 5'd24, 6'd61, 6'd0);
    chk_out("range", 8'h24, 8'h61, 8'h00, 1'b0, 1'b1);
    conv("r12", 1'b1, 5'd25, 6'd0, 6'd0);
    chk_out("r12", 8'hF1, 8'h00, 8'h00, 1'b1, 1'b1);
    conv("clr", 1'b0, 5'd10, 6'd20, 6'd30);
    chk_out("clr", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

    // Reset at edge N+3 of a running conversion.
    start_conv(1'b1, 5'd14, 6'd20, 6'd30);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("mrst_busy", o_busy, 0);
    chk_out("mrst", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
    end
    chk("mrst_novalid", vcnt, 0);

    // Reset coincident with start: nothing starts.
    i_reset = 1'b1;
    start_conv(1'b0, 5'd11, 6'd11, 6'd11);
    i_reset = 1'b0;
    chk("rststart_busy", o_busy, 0);
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_valid) vcnt++;
      if (o_busy) bcnt++;
    end
    chk("rststart_novalid", vcnt, 0);
    chk("rststart_nobusy", bcnt, 0);

    conv("post", 1'b0, 5'd23, 6'd59, 6'd59);
    chk_out("post", 8'h23, 8'h59, 8'h59, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_bcd_formatter.md
# time_bcd_formatter

Sequential successor to the combinational 12/24-hour mode converter. It captures a binary hours/minutes/seconds sample on a start strobe and applies the 12-hour mapping and AM/PM flag. It then converts all three fields to two-digit BCD with an iterative shift-add-3 engine and presents registered digits with a one-cycle valid pulse. It sits between the time/alarm registers and the display driver.

## Interface
- HOUR_W, default 5: width of the binary hours input.
- MINSEC_W, default 6: width of the minutes/seconds inputs and the number of shift iterations. Must be ≥ HOUR_W and ≤ 6; the two-digit BCD limit is 99, and the check below uses 60.
- BLANK_LEADING, default 1: in 12h mode, replace a zero hour-tens digit with the blank code 4'hF.
- i_clk  in  1  system clock; all logic is rising-edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  conversion request; sampled only when o_busy=0.
- i_12h_mode  in  1  1 = 12-hour display, 0 = 24-hour display; sampled with i_start.
- i_hours  in  HOUR_W  binary hours.
- i_minutes  in  MINSEC_W  binary minutes.
- i_seconds  in  MINSEC_W  binary seconds.
- o_busy  out  1  conversion in progress.
- o_valid  out  1  one-cycle pulse: digit outputs updated.
- o_hour_tens, o_hour_ones  out  4 each  BCD hour digits.
- o_min_tens, o_min_ones  out  4 each  BCD minute digits.
- o_sec_tens, o_sec_ones  out  4 each  BCD second digits.
- o_am_pm  out  1  1 = PM; always 0 in 24h mode.
- o_range_err  out  1  input out of range in the last completed conversion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when i_start=1:
  - Latch mode, fields and range check.
  - Map hours: 24h mode passes them through. 12h mode maps 0→12, 12→12, otherwise h mod 12. PM flag = (h ≥ 12) in 12h mode only.
  - Zero-extend mapped hours to MINSEC_W.
  - Clear three 8-bit BCD accumulators.
  - Load the iteration counter with MINSEC_W.
- SHIFT: one double-dabble iteration per cycle, on all three fields in parallel.
  - Each BCD nibble ≥ 5 gets +3 first.
  - Then shift left one bit, taking the next MSB of the field.
  - Counter decrements. At the edge where the counter reaches 0, go to DONE.
- DONE:
  - Register all digits, o_am_pm and o_range_err; pulse o_valid.
  - Return to IDLE.
  - Apply blanking: o_hour_tens=4'hF when BLANK_LEADING=1, 12h mode, and tens digit = 0.
- Range error: hours ≥ 24, minutes ≥ 60, or seconds ≥ 60.
  - Conversion still completes; out-of-range values are displayed numerically.
  - In 12h mode hours ≥ 24 still map mod 12, e.g. 25→1 with PM.
- i_start while busy is ignored; it is not queued.
- Inputs and mode changing after the start edge do not affect the running conversion.
- Digit outputs hold their last completed values between conversions.

## Timing
- Reset (synchronous): state IDLE; all digits 0; o_am_pm, o_valid, o_busy, o_range_err = 0.
- Start sampled at edge N:
  - o_busy=1 after edge N.
  - Shift edges N+1 … N+MINSEC_W.
  - Edge N+MINSEC_W+1: outputs update, o_valid=1 for exactly one cycle, o_busy=0.
- Latency is MINSEC_W+1 cycles (7 at default).
- Earliest next start: the edge after the o_valid edge, while o_valid is high. Back-to-back throughput is one result per MINSEC_W+2 cycles.
- Reset asserted mid-conversion: at that edge return to IDLE with reset values. No o_valid follows.
- Reset and i_start at the same edge: reset wins.

## Test plan
- 24h mode, 13:45:09, start at edge N → at edge N+7: digits 1,3 / 4,5 / 0,9; o_am_pm=0; o_range_err=0; o_valid high one cycle; o_busy high cycles N+1…N+7.
- 12h mode, 00:00:00 → hour 1,2; all other digits 0; o_am_pm=0. Then 12h mode, 13:05:59 → hour tens 4'hF, ones 1, digits 0,5 / 5,9, o_am_pm=1.
- 12h mode, hour 12 → 1,2 with o_am_pm=1. Same input with BLANK_LEADING=0 and hour 9 → hour tens 0, ones 9, o_am_pm=0.
- Second i_start at cycle N+3 and i_12h_mode toggled at N+2 → exactly one o_valid at N+7, results match the original sample. Next start at N+8 is accepted.
- 24h mode, 24:61:00 → digits 2,4 / 6,1 / 0,0; o_range_err=1. Following in-range conversion clears o_range_err.
- Reset at edge N+3 of a conversion → o_busy=0, all digits 0, no o_valid for 10 cycles. Reset held coincident with i_start → no conversion starts.
